// File: rtl/conv_accum_if.sv
// conv_accum_if
//   Bundles the three streaming links of the convolution accumulate controller:
//     s_axis_*      product stream from the multiplier array
//     m_axis_*      group-sum stream to the output writer
//     add_a/b_*     operands to the shared 1-cycle integer adder
//     add_result_*  result back from that adder (zero when not valid)
//   Modports:
//     slave  - the controller side
//     master - the environment side (multiplier, writer, adder)
interface conv_accum_if #(
   parameter int DataWidth = 32
);
   logic                 s_axis_tvalid;
   logic                 s_axis_tready;
   logic [DataWidth-1:0] s_axis_tdata;

   logic                 m_axis_tvalid;
   logic                 m_axis_tready;
   logic [DataWidth-1:0] m_axis_tdata;

   logic                 add_a_tvalid;
   logic                 add_b_tvalid;
   logic [DataWidth-1:0] add_a_tdata;
   logic [DataWidth-1:0] add_b_tdata;
   logic                 add_result_tvalid;
   logic [DataWidth-1:0] add_result_tdata;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata,
      output s_axis_tready,
      output m_axis_tvalid, m_axis_tdata,
      input  m_axis_tready,
      output add_a_tvalid, add_b_tvalid, add_a_tdata, add_b_tdata,
      input  add_result_tvalid, add_result_tdata
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata,
      input  s_axis_tready,
      input  m_axis_tvalid, m_axis_tdata,
      output m_axis_tready,
      input  add_a_tvalid, add_b_tvalid, add_a_tdata, add_b_tdata,
      output add_result_tvalid, add_result_tdata
   );
endinterface

// File: rtl/conv_accum_ctrl.sv
// conv_accum_ctrl
//   Sums groups of partial products for one convolution output using a shared
//   1-cycle-latency adder. Each accepted product is sent to the adder together
//   with the running partial sum; the last beat's result becomes the group sum.
//   Ports:
//     aclk     clock, rising edge
//     areset   synchronous active-high reset
//     cfg_len  terms per group, captured on the first beat of a group (0 -> 1)
//     busy     group in progress or sum waiting for downstream
//     bus      product / sum / adder links (conv_accum_if.slave)
module conv_accum_ctrl #(
   parameter int DataWidth = 32,
   parameter int LenWidth  = 8
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [LenWidth-1:0] cfg_len,
   output logic                busy,
   conv_accum_if.slave         bus
);

   typedef enum logic [1:0] {
      ACC  = 2'd0,   // accepting products
      WAIT = 2'd1,   // last result arriving from the adder
      OUT  = 2'd2    // group sum presented downstream
   } state_e;

   state_e               state_q, state_d;
   logic [LenWidth-1:0]  cnt_q, cnt_d;
   logic [LenWidth-1:0]  len_q, len_d;
   logic [DataWidth-1:0] acc_q, acc_d;
   logic [DataWidth-1:0] m_tdata_q, m_tdata_d;
   logic                 m_tvalid_q, m_tvalid_d;

   logic                 s_tready;
   logic                 accept;
   logic [LenWidth-1:0]  eff_len;
   logic                 last_beat;

   // Ready depends only on state and reset, never on m_axis_tready.
   assign s_tready = (state_q == ACC) && !areset;
   assign accept   = bus.s_axis_tvalid && s_tready;

   // On the first beat the live cfg_len is used; afterwards the latched length.
   assign eff_len   = (cnt_q != '0) ? len_q :
                      (cfg_len == '0) ? LenWidth'(1) : cfg_len;
   assign last_beat = (cnt_q == eff_len - LenWidth'(1));

   assign bus.s_axis_tready = s_tready;
   assign bus.m_axis_tvalid = m_tvalid_q;
   assign bus.m_axis_tdata  = m_tdata_q;
   assign bus.add_a_tvalid  = accept;
   assign bus.add_b_tvalid  = accept;
   assign bus.add_a_tdata   = bus.s_axis_tdata;
   // Forward the result arriving this cycle; otherwise the held partial sum.
   assign bus.add_b_tdata   = (cnt_q == '0)          ? '0 :
                              bus.add_result_tvalid  ? bus.add_result_tdata : acc_q;
   assign busy              = (state_q != ACC) || (cnt_q != '0);

   always_comb begin
      // NOTE: every _d gets a default so no path through the case infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      m_tdata_d  = m_tdata_q;
      m_tvalid_d = m_tvalid_q;
      // The adder outputs zero on idle cycles, so only valid results update acc.
      acc_d      = bus.add_result_tvalid ? bus.add_result_tdata : acc_q;

      case (state_q)
         ACC: begin
            if (accept) begin
               if (cnt_q == '0) len_d = eff_len;
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = WAIT;
               end else begin
                  cnt_d = cnt_q + LenWidth'(1);
               end
            end
         end
         WAIT: begin
            m_tdata_d  = bus.add_result_tdata;
            m_tvalid_d = 1'b1;
            state_d    = OUT;
         end
         OUT: begin
            if (bus.m_axis_tready) begin
               m_tvalid_d = 1'b0;
               state_d    = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge aclk) begin
      // NOTE: state uses non-blocking assignments so all flops update together.
      if (areset) begin
         state_q    <= ACC;
         cnt_q      <= '0;
         len_q      <= '0;
         acc_q      <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         acc_q      <= acc_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
      end
   end

endmodule

// File: doc/conv_accum_ctrl.md
# conv_accum_ctrl

Sequencer that drives the shared 1-cycle-latency integer adder (valid-only operand/result interface, no stall) to sum groups of partial products for one convolution output. Accepts a product stream, feeds each beat plus the running partial sum into the adder, keeps the partial sum across input gaps, and emits one sum per group. It sits between the multiplier array and the output writer in the ConvCtrl datapath.

## Interface
- DataWidth, 32, width of products, adder operands and sums
- LenWidth, 8, width of the group-length input
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- cfg_len  in  LenWidth  terms per group; sampled on first accepted beat of each group; 0 treated as 1
- s_axis_tvalid  in  1  product valid
- s_axis_tready  out  1  controller accepts product
- s_axis_tdata  in  DataWidth  product
- m_axis_tvalid  out  1  group sum valid
- m_axis_tready  in  1  downstream accepts sum
- m_axis_tdata  out  DataWidth  group sum
- add_a_tvalid, add_b_tvalid  out  1  adder operand valids (identical)
- add_a_tdata, add_b_tdata  out  DataWidth  adder operands
- add_result_tvalid  in  1  adder result valid (1 cycle after operands)
- add_result_tdata  in  DataWidth  adder result (adder forces 0 when not valid)
- busy  out  1  group in progress or sum pending

## Operation
- States: ACC, WAIT, OUT. Registers: state, cnt (LenWidth), len (LenWidth), acc (DataWidth), m_axis_tdata, m_axis_tvalid.
- accept = s_axis_tvalid & s_axis_tready. s_axis_tready = 1 only in ACC and areset low.
- Operand drive (combinational): add_a/b_tvalid = accept; add_a_tdata = s_axis_tdata; add_b_tdata = 0 if cnt==0, else add_result_tdata when add_result_tvalid, else acc (forwarding).
- acc loads add_result_tdata whenever add_result_tvalid; holds otherwise (adder zeroes its output on idle cycles, so acc is the only persistent partial sum).
- ACC: on accept with cnt==0 latch len = max(cfg_len,1). If accepted beat is last (cnt == effective len-1): cnt<=0, go WAIT; else cnt<=cnt+1. cfg_len changes mid-group ignored.
- WAIT (1 cycle): add_result_tvalid is high; m_axis_tdata<=add_result_tdata, m_axis_tvalid<=1, go OUT.
- OUT: hold m_axis_tdata/tvalid stable until m_axis_tready; on handshake m_axis_tvalid<=0, go ACC.
- Arithmetic modulo 2^DataWidth (wrap, no saturation, no overflow flag).
- busy = (state != ACC) | (cnt != 0).
- Reset mid-group: partial group discarded; next accepted beat starts a new group (cnt==0, b operand 0). Adder has no reset; a stray result arriving after reset only updates acc and is never used.

## Timing
- Reset values: state ACC, cnt 0, len 0, acc 0, m_axis_tvalid 0, m_axis_tdata 0; s_axis_tready 0 while areset high, 1 the first cycle after.
- Beat accepted cycle t -> adder result at t+1.
- Last beat accepted cycle t: WAIT at t+1, m_axis_tvalid high from t+2.
- Sum handshake cycle u: s_axis_tready high from u+1.
- Max throughput: one group per len+2 cycles with m_axis_tready held high; back-to-back beats within a group at 1/cycle.
- No combinational path from m_axis_tready to s_axis_tready.

## Test plan
- cfg_len=3, beats 1,2,3 back-to-back -> m_axis_tdata=6, m_axis_tvalid 2 cycles after beat 3; s_axis_tready low in WAIT/OUT.
- cfg_len=4, beats 10,20,30,40 with 2 idle cycles between each -> 100 (acc held across adder-zero cycles).
- cfg_len=2, beats 0xFFFFFFFF, 0x2 -> 0x00000001 (wrap).
- m_axis_tready low 5 cycles after sum 6 -> tdata stable at 6, tvalid high, no beats accepted, busy=1; accepted on tready -> s_axis_tready high next cycle.
- cfg_len=0 with beat 7 -> 7; cfg_len=3 changed to 1 after first beat of 1,1,1 -> 3.
- cfg_len=3, beats 5,5 then areset 1 cycle, then 4,5,6 -> single output 15, no output for discarded group.
